// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter
//
// Arbitrates the instruction L2 and data L2 onto a single main-memory port. Only one memory
// transaction is in flight at a time. Ties are broken round-robin. Every memory wait is bounded
// by a timeout that completes the transaction with err set.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req, i_addr         instruction read request (4-aligned byte address), held until i_done
//   i_rdata, i_done       returned instruction word, one-cycle completion pulse
//   d_req, d_we, d_addr,  data request: read refill or write-through (8-aligned byte address),
//   d_wdata               held until d_done
//   d_rdata, d_done       returned data word (0 for writes), one-cycle completion pulse
//   err                   qualifies i_done/d_done: the transaction timed out
//   mem_req, mem_we,      memory request, held until mem_ack; address is always 8-aligned
//   mem_addr, mem_wdata
//   mem_ack, mem_rdata    one-cycle acknowledge with read data in the same cycle
//   busy                  high whenever a transaction is in progress (WAIT or RESP)

module l2_mem_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_done,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic [63:0]       d_rdata,
    output logic              d_done,

    output logic              err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef enum logic {
        OwnInstr,
        OwnData
    } owner_e;

    // Counter value of the last WAIT cycle before the transaction is abandoned.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    owner_e            last_grant_q;
    owner_e            owner_q;
    logic              wsel_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [63:0]       mem_wdata_q;
    logic [31:0]       i_rdata_q;
    logic [63:0]       d_rdata_q;
    logic              i_done_q;
    logic              d_done_q;
    logic              err_q;
    logic              busy_q;

    // Sub-word address bits are not needed: memory is addressed in 64-bit words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[2:0]};

    // ------------------------------------------------------------------------
    // Grant selection (only consumed in IDLE)
    // ------------------------------------------------------------------------
    logic   grant_valid;
    owner_e grant_owner;

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OwnInstr;
        // Data wins when it is alone, or on a tie when instruction was served last.
        if (d_req && (!i_req || (last_grant_q == OwnInstr))) begin
            grant_owner = OwnData;
        end
    end

    // ------------------------------------------------------------------------
    // Response data selection
    // ------------------------------------------------------------------------
    logic [31:0] i_word;
    logic        timeout_hit;

    always_comb begin
        i_word      = wsel_q ? mem_rdata[63:32] : mem_rdata[31:0];
        timeout_hit = (cnt_q == CntLast);
    end

    // ------------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= OwnData;
            owner_q      <= OwnInstr;
            wsel_q       <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle.
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    err_q <= 1'b0;
                    if (grant_valid) begin
                        state_q      <= StWait;
                        busy_q       <= 1'b1;
                        mem_req_q    <= 1'b1;
                        cnt_q        <= '0;
                        owner_q      <= grant_owner;
                        last_grant_q <= grant_owner;
                        if (grant_owner == OwnData) begin
                            mem_addr_q  <= {d_addr[ADDR_W-1:3], 3'b000};
                            mem_we_q    <= d_we;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            mem_addr_q  <= {i_addr[ADDR_W-1:3], 3'b000};
                            mem_we_q    <= 1'b0;
                            wsel_q      <= i_addr[2];
                        end
                    end
                end

                StWait: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (mem_ack || timeout_hit) begin
                        state_q   <= StResp;
                        mem_req_q <= 1'b0;
                        err_q     <= ~mem_ack;
                        if (owner_q == OwnData) begin
                            d_done_q  <= 1'b1;
                            d_rdata_q <= (mem_ack && !mem_we_q) ? mem_rdata : '0;
                        end else begin
                            i_done_q  <= 1'b1;
                            i_rdata_q <= mem_ack ? i_word : '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign busy      = busy_q;

    // ------------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------------
    a_one_done : assert property (@(posedge clk) disable iff (!rst_n) !(i_done && d_done));
    a_req_busy : assert property (@(posedge clk) disable iff (!rst_n) mem_req |-> busy);

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Randomized bench for l2_mem_arbiter. A memory responder models the arbitration rules at
// transaction level and pushes the expected completion into a scoreboard; a monitor pops and
// compares whenever a done pulse appears.

module tb_l2_mem_arbiter;

    localparam int unsigned ADDR_W  = 64;
    localparam int          TIMEOUT = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int          AGE_MAX = 4 * (TIMEOUT + 3);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic [63:0]       d_rdata;
    logic              d_done;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_ack;
    logic [63:0]       mem_rdata;
    logic              busy;

    l2_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        bit          port_d;
        bit          err;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];

    // Request inputs as seen by the DUT at the most recent rising edge.
    logic              snap_i, snap_d, snap_dwe;
    logic [ADDR_W-1:0] snap_iaddr, snap_daddr;
    logic [63:0]       snap_dwdata;

    always @(posedge clk) begin
        snap_i      = i_req;
        snap_d      = d_req;
        snap_dwe    = d_we;
        snap_iaddr  = i_addr;
        snap_daddr  = d_addr;
        snap_dwdata = d_wdata;
    end

    // Responder controls, written by the stimulus process.
    int          forced_k = -1;  // ack after this many extra WAIT cycles; >= TIMEOUT means never
    logic [63:0] forced_data = '0;
    bit          spur_en = 1'b0; // random acks while no request is outstanding

    // ------------------------------------------------------------------------
    // Memory responder and reference model
    // ------------------------------------------------------------------------
    bit                in_txn = 1'b0;
    bit                skip = 1'b0;   // next idle observation follows a completion
    bit                m_last = 1'b1; // 1 = data served last
    bit                t_owner_d;
    int                cyc;
    int                t_k;
    logic [63:0]       t_data;
    logic [ADDR_W-1:0] t_addr;
    bit                t_we;
    logic [63:0]       t_wdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn    = 1'b0;
            skip      = 1'b0;
            m_last    = 1'b1;
            sb.delete();
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end else begin
            exp_t e;
            mem_ack   = 1'b0;
            mem_rdata = rnd64();
            if (mem_req) begin
                if (!in_txn) begin
                    if (skip) fail("idle_gap", "mem_req=1 in the idle cycle, expected 0");
                    skip = 1'b0;
                    if (!snap_i && !snap_d) fail("grant", "mem_req=1 with no request, expected 0");
                    // Round robin: a lone requester wins; on a tie the one not served last.
                    t_owner_d = snap_d && (!snap_i || !m_last);
                    m_last    = t_owner_d;
                    t_addr    = t_owner_d ? snap_daddr : snap_iaddr;
                    t_addr[2:0] = 3'b000;
                    t_we      = t_owner_d && snap_dwe;
                    t_wdata   = snap_dwdata;
                    t_k       = (forced_k >= 0) ? forced_k : $urandom_range(0, TIMEOUT);
                    t_data    = (forced_k >= 0) ? forced_data : rnd64();
                    e.port_d  = t_owner_d;
                    e.err     = (t_k >= TIMEOUT);
                    if (e.err) e.data = '0;
                    else if (t_owner_d) e.data = t_we ? 64'd0 : t_data;
                    else e.data = snap_iaddr[2] ? {32'd0, t_data[63:32]} : {32'd0, t_data[31:0]};
                    sb.push_back(e);
                    in_txn = 1'b1;
                    cyc    = 0;
                end
                check("mem_addr", mem_addr, t_addr);
                check("mem_we", {63'd0, mem_we}, {63'd0, t_we});
                if (t_owner_d) check("mem_wdata", mem_wdata, t_wdata);
                check("busy_wait", {63'd0, busy}, 64'd1);
                if (cyc == t_k) begin
                    mem_ack   = 1'b1;
                    mem_rdata = t_data;
                end
                if (cyc == TIMEOUT + 1) fail("mem_req_len", "mem_req still high past the timeout");
                cyc++;
            end else begin
                if (in_txn) begin
                    check("mem_req_cycles", 64'(cyc), 64'((t_k < TIMEOUT) ? t_k + 1 : TIMEOUT));
                    in_txn = 1'b0;
                    skip   = 1'b1;
                end else if (skip) begin
                    skip = 1'b0;
                end else if (snap_i || snap_d) begin
                    fail("grant_latency", "mem_req=0 one cycle after an idle request, expected 1");
                end
                if (spur_en && ($urandom_range(0, 1) == 0)) mem_ack = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Completion monitor
    // ------------------------------------------------------------------------
    logic [63:0] last_i = '0;
    logic [63:0] last_d = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_i = '0;
            last_d = '0;
        end else begin
            exp_t e;
            if (i_done && d_done) fail("both_done", "i_done=1 and d_done=1, expected at most one");
            if (i_done || d_done) begin
                if (sb.size() == 0) begin
                    fail("unexpected_done", "done pulse with no transaction outstanding");
                end else begin
                    e = sb.pop_front();
                    check("done_port", {63'd0, d_done}, {63'd0, e.port_d});
                    check("err", {63'd0, err}, {63'd0, e.err});
                    check("busy_resp", {63'd0, busy}, 64'd1);
                    if (e.port_d) begin
                        check("d_rdata", d_rdata, e.data);
                        check("i_rdata_hold", {32'd0, i_rdata}, last_i);
                        last_d = e.data;
                    end else begin
                        check("i_rdata", {32'd0, i_rdata}, e.data);
                        check("d_rdata_hold", d_rdata, last_d);
                        last_i = e.data;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Requesters
    // ------------------------------------------------------------------------
    int i_left = 0, d_left = 0;
    int i_age = 0, d_age = 0;
    int raise_pct = 0;
    bit hold_all = 1'b0;

    task automatic new_i();
        logic [63:0] a;
        a = rnd64();
        a[1:0] = 2'b00;
        i_addr = a;
    endtask

    task automatic new_d();
        logic [63:0] a;
        a = rnd64();
        a[2:0] = 3'b000;
        d_addr  = a;
        d_we    = $urandom_range(0, 1) == 1;
        d_wdata = rnd64();
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        if (i_req) begin
            if (i_done) begin
                i_left--;
                i_age = 0;
                // Keeping req high through done makes it a new request.
                if (i_left > 0 && (hold_all || $urandom_range(0, 1) == 1)) new_i();
                else i_req = 1'b0;
            end else if (++i_age > AGE_MAX) begin
                fail("i_starved", "i_req never completed within the cycle budget");
                i_req = 1'b0; i_left = 0; i_age = 0;
            end
        end else if (i_left > 0 && $urandom_range(0, 99) < raise_pct) begin
            new_i();
            i_req = 1'b1;
        end
        if (d_req) begin
            if (d_done) begin
                d_left--;
                d_age = 0;
                if (d_left > 0 && (hold_all || $urandom_range(0, 1) == 1)) new_d();
                else d_req = 1'b0;
            end else if (++d_age > AGE_MAX) begin
                fail("d_starved", "d_req never completed within the cycle budget");
                d_req = 1'b0; d_left = 0; d_age = 0;
            end
        end else if (d_left > 0 && $urandom_range(0, 99) < raise_pct) begin
            new_d();
            d_req = 1'b1;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (n < budget && (i_left > 0 || d_left > 0 || i_req || d_req ||
                                  sb.size() != 0 || in_txn || mem_req));
        if (n >= budget) fail("drain", "transactions still outstanding at the cycle budget");
        repeat (2) cycle();
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n;
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_i_done", {63'd0, i_done}, 64'd0);
        check("rst_d_done", {63'd0, d_done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_i_rdata", {32'd0, i_rdata}, 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        rst_n = 1'b1;

        // Instruction fetch of the upper word.
        forced_k = 3; forced_data = 64'hAAAA_BBBB_1111_2222;
        i_addr = 64'h1004; i_left = 1; i_req = 1'b1;
        drain(100);
        check("fetch_word", {32'd0, i_rdata}, 64'hAAAA_BBBB);

        // Data write-through.
        forced_k = 1;
        d_we = 1'b1; d_addr = 64'h2008; d_wdata = 64'hDEAD_BEEF_0000_0001;
        d_left = 1; d_req = 1'b1;
        drain(100);
        check("write_rdata", d_rdata, 64'd0);

        // Contention: both held high across completions.
        forced_k = -1; hold_all = 1'b1;
        i_addr = 64'h3000; d_addr = 64'h3808; d_we = 1'b0;
        i_left = 2; d_left = 2; i_req = 1'b1; d_req = 1'b1;
        drain(200);
        hold_all = 1'b0;

        // Timeout with late acks afterwards.
        forced_k = TIMEOUT; spur_en = 1'b1;
        d_we = 1'b0; d_addr = 64'h4000; d_left = 1; d_req = 1'b1;
        drain(100);
        repeat (4) cycle();
        check("timeout_rdata", d_rdata, 64'd0);
        spur_en = 1'b0;

        // Ack in the final timeout cycle.
        forced_k = TIMEOUT - 1; forced_data = 64'h0123_4567_89AB_CDEF;
        d_we = 1'b0; d_addr = 64'h4808; d_left = 1; d_req = 1'b1;
        drain(100);
        check("tie_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);

        // Asynchronous reset in the middle of WAIT.
        forced_k = TIMEOUT;
        d_we = 1'b0; d_addr = 64'h5000; d_left = 1; d_req = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!mem_req && n < 10);
        if (!mem_req) fail("reset_setup", "mem_req=0, expected 1 before reset");
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_req", {63'd0, mem_req}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_d_done", {63'd0, d_done}, 64'd0);
        i_req = 1'b0; i_left = 0; i_age = 0;
        d_req = 1'b0; d_left = 0; d_age = 0;
        forced_k = -1; spur_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        i_addr = 64'h6000; i_left = 1; i_req = 1'b1;
        drain(100);

        // Randomized traffic.
        raise_pct = 40; i_left = 40; d_left = 40;
        drain(4000);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
